// File: rtl/gcd_engine.sv
// gcd_engine: serial-entry GCD coprocessor, one subtraction per clock.
// Optional GCD_STEP_COUNT_EN adds a saturating Steps output counting RUN subtractions.
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enter,
  input  logic [WIDTH-1:0] Input,
  output logic [WIDTH-1:0] Output,
  output logic             Halt,
  output logic             Busy,
  output logic             Err,
`ifdef GCD_STEP_COUNT_EN
  output logic [WIDTH-1:0] Steps,
`endif
  output logic [2:0]       state
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOADY = 3'd1, RUN = 3'd2, DONE = 3'd3} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, out_q, out_d;
  logic err_q, err_d, enter_q, rise;
  assign rise = Enter & ~enter_q;
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      out_q   <= out_d;
      err_q   <= err_d;
      enter_q <= Enter;
    end
  end
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      IDLE:  if (rise) begin
        x_d     = Input;
        state_d = LOADY;
      end
      LOADY: if (rise) begin
        y_d     = Input;
        state_d = RUN;
      end
      RUN: begin
        // Equal operands (including both zero) finish first; a zero operand yields the other.
        if (x_q == y_q) begin
          out_d   = x_q;
          err_d   = (x_q == '0);
          state_d = DONE;
        end else if (x_q == '0 || y_q == '0) begin
          out_d   = (x_q == '0) ? y_q : x_q;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (x_q > y_q) x_d = x_q - y_q;
        else y_d = y_q - x_q;
      end
      DONE:  if (rise) begin
        x_d     = Input;
        err_d   = 1'b0;
        state_d = LOADY;
      end
      default: state_d = IDLE;
    endcase
  end
  assign Output = out_q;
  assign Halt   = (state_q == DONE);
  assign Busy   = (state_q == RUN);
  assign Err    = err_q;
  assign state  = state_q;
`ifdef GCD_STEP_COUNT_EN
  logic [WIDTH-1:0] steps_q, steps_d;
  logic sub;
  assign sub = (state_q == RUN) && (x_q != y_q) && (x_q != '0) && (y_q != '0);
  always_comb steps_d = (state_q == LOADY && rise) ? '0 : (sub && ~&steps_q) ? steps_q + 1'b1 : steps_q;
  always_ff @(posedge Clock) steps_q <= !Reset ? '0 : steps_d;
  assign Steps = steps_q;
`endif
endmodule
